// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: width default, load/store width codes,
// FSM state encoding and request kind.
package mem_access_unit_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10,
    ST_ERR   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    K_FETCH = 2'b00,
    K_LOAD  = 2'b01,
    K_STORE = 2'b10
  } kind_e;

  // A fetch takes precedence over the write flag.
  function automatic kind_e decode_kind(input logic fetch, input logic write);
    if (fetch)      return K_FETCH;
    else if (write) return K_STORE;
    else            return K_LOAD;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the access unit: req/ready handshake with same-cycle completion.
interface mem_access_unit_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction/extension
// and alignment/legality checks for one access.
module lsu_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  kind_e           kind,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] load_ext,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
    be         = '0;
    wdata_rep  = wdata;
    load_ext   = rdata;
    misaligned = 1'b0;
    illegal    = 1'b0;

    if (kind == K_FETCH) begin
      be         = 4'b1111;
      misaligned = (addr_lo != 2'b00);
    end else begin
      case (funct3[1:0])
        2'b00: begin
          be        = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end
        2'b01: begin
          be         = 4'b0011 << {addr_lo[1], 1'b0};
          wdata_rep  = {2{wdata[15:0]}};
          misaligned = addr_lo[0];
        end
        2'b10: begin
          be         = 4'b1111;
          misaligned = (addr_lo != 2'b00);
        end
        default: be = '0;
      endcase

      // Stores have no unsigned variants; loads have no 011/110/111 encodings.
      if (kind == K_STORE) illegal = (funct3 >= 3'b011);
      else                 illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end

    case (funct3)
      F3_B:    load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   load_ext = {{(XLEN-16){1'b0}}, half_sel};
      F3_W:    load_ext = rdata;
      default: load_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle fetch/load/store port between the core controller and the unified memory:
// IDLE -> ISSUE (bus handshake, timeout) -> DONE, or straight to ERR for illegal requests.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_fetch,
  input  logic               req_write,
  input  logic [2:0]         funct3,
  input  logic [XLEN-1:0]    addr,
  input  logic [XLEN-1:0]    wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [XLEN-1:0]    ir_out,
  output logic [XLEN-1:0]    mdr_out,
  mem_access_unit_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  logic [XLEN-1:0]  mdr_q, mdr_d;

  logic             idle;
  kind_e            al_kind;
  logic [2:0]       al_funct3;
  logic [1:0]       al_addr_lo;
  logic [XLEN-1:0]  al_wdata;
  logic [3:0]       al_be;
  logic [XLEN-1:0]  al_wdata_rep;
  logic [XLEN-1:0]  al_load_ext;
  logic             al_misaligned;
  logic             al_illegal;

  // The aligner checks the raw request while idle, then works from the latched copy.
  assign idle       = (state_q == ST_IDLE);
  assign al_kind    = idle ? decode_kind(req_fetch, req_write) : kind_q;
  assign al_funct3  = idle ? funct3 : funct3_q;
  assign al_addr_lo = idle ? addr[1:0] : addr_q[1:0];
  assign al_wdata   = idle ? wdata : wdata_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .kind       (al_kind),
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .wdata      (al_wdata),
    .rdata      (bus.mem_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata_rep),
    .load_ext   (al_load_ext),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          kind_d   = al_kind;
          funct3_d = funct3;
          addr_d   = addr;
          wdata_d  = wdata;
          state_d  = (al_misaligned || al_illegal) ? ST_ERR : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_ready) begin
          state_d = ST_DONE;
          if (kind_q == K_FETCH)     ir_d  = bus.mem_rdata;
          else if (kind_q == K_LOAD) mdr_d = al_load_ext;
        end else if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= ST_IDLE;
      kind_q   <= K_FETCH;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      ir_q     <= '0;
      mdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
    end
  end

  // Bus outputs are gated by ISSUE so an async reset drops them in the same instant.
  assign busy          = !idle;
  assign done          = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign err           = (state_q == ST_ERR);
  assign ir_out        = ir_q;
  assign mdr_out       = mdr_q;
  assign bus.mem_req   = (state_q == ST_ISSUE);
  assign bus.mem_we    = bus.mem_req && (kind_q == K_STORE);
  assign bus.mem_addr  = bus.mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign bus.mem_be    = bus.mem_req ? al_be : 4'b0000;
  assign bus.mem_wdata = bus.mem_we ? al_wdata_rep : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus random fetch/load/store traffic
// checked against a behavioural model of the access rules.
module tb_mem_access_unit;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_fetch, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] ir_out, mdr_out;

  mem_access_unit_if #(.XLEN(32)) bus ();

  mem_access_unit #(.XLEN(32), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_fetch (req_fetch),
    .req_write (req_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ir_out    (ir_out),
    .mdr_out   (mdr_out),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] ir;
    logic [31:0] mdr;
    int          done_cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_be;
    bit          chk_wd;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  logic [31:0] ir_m  = '0;
  logic [31:0] mdr_m = '0;

  // ---------------- reference model ----------------
  function automatic bit legal(bit fetch, bit write, logic [2:0] f3, logic [31:0] a);
    int sz;
    if (fetch) return (a % 4) == 0;
    if (write && f3 > 3'd2) return 0;
    if (!write && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 0;
    sz = 1 << f3[1:0];
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] load_val(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    logic [31:0] v;
    int off;
    off = int'(a % 4);
    case (f3)
      3'd0, 3'd4: begin
        v = (rd >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (rd >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic bus_t bus_model(bit fetch, bit write, logic [2:0] f3, logic [31:0] a,
                                     logic [31:0] wd);
    bus_t b;
    int off;
    off      = int'(a % 4);
    b.we     = write && !fetch;
    b.addr   = a & ~32'd3;
    b.chk_be = fetch || write;
    b.chk_wd = b.we;
    b.be     = 4'hF;
    b.wdata  = wd;
    if (b.we) begin
      if (f3 == 3'd0) begin
        b.be    = 4'(1 << off);
        b.wdata = (wd & 32'hFF) * 32'h0101_0101;
      end else if (f3 == 3'd1) begin
        b.be    = 4'(3 << (2 * (off / 2)));
        b.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      end
    end
    return b;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        check("busy_on_done", 32'(busy), 32'd1);
        if (resp_q.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          check("err", 32'(err), 32'(e.err));
          check("ir_out", ir_out, e.ir);
          check("mdr_out", mdr_out, e.mdr);
          check("done_cycle", cyc, e.done_cyc);
        end
      end else begin
        check("err_without_done", 32'(err), 32'd0);
      end

      if (bus.mem_req) begin
        if (bus_q.size() == 0) begin
          check("mem_req_unexpected", 32'(bus.mem_req), 32'd0);
        end else begin
          bus_t b;
          b = bus_q[0];
          check("mem_we", 32'(bus.mem_we), 32'(b.we));
          check("mem_addr", bus.mem_addr, b.addr);
          if (b.chk_be) check("mem_be", 32'(bus.mem_be), 32'(b.be));
          if (b.chk_wd) check("mem_wdata", bus.mem_wdata, b.wdata);
          if (bus.mem_ready) void'(bus_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input bit fetch, input bit write, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int wait_n, input bit timeout);
    resp_t e;
    bit ok;
    ok = legal(fetch, write, f3, a);

    @(negedge clk);
    req_valid = 1'b1;
    req_fetch = fetch;
    req_write = write;
    funct3    = f3;
    addr      = a;
    wdata     = wd;

    if (ok && !timeout) begin
      if (fetch)       ir_m  = rd;
      else if (!write) mdr_m = load_val(f3, a, rd);
    end
    e.err      = !ok || timeout;
    e.ir       = ir_m;
    e.mdr      = mdr_m;
    e.done_cyc = cyc + (!ok ? 1 : (timeout ? TO + 1 : wait_n + 2));
    resp_q.push_back(e);
    if (ok) bus_q.push_back(bus_model(fetch, write, f3, a, wd));

    @(posedge clk); #1;
    if (!ok) begin
      req_valid = 1'b0;
    end else if (timeout) begin
      bus.mem_ready = 1'b0;
      for (int i = 0; i < TO; i++) begin
        req_valid     = 1'($urandom);
        bus.mem_rdata = $urandom;
        @(posedge clk); #1;
      end
      req_valid = 1'b0;
      void'(bus_q.pop_front());
    end else begin
      for (int w = 0; w <= wait_n; w++) begin
        bus.mem_ready = (w == wait_n);
        bus.mem_rdata = (w == wait_n) ? rd : $urandom;
        req_valid     = (w == wait_n) ? 1'b0 : 1'($urandom);
        req_fetch     = 1'($urandom);
        req_write     = 1'($urandom);
        funct3        = 3'($urandom);
        addr          = $urandom;
        wdata         = $urandom;
        @(posedge clk); #1;
      end
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check({tag, "_mem_be"}, 32'(bus.mem_be), 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_ir_out"}, ir_out, 32'd0);
    check({tag, "_mdr_out"}, mdr_out, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_fetch = 1'b0; req_write = 1'b0;
    funct3 = '0; addr = '0; wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_req(1, 0, 3'd2, 32'h0000_0100, 32'h0, 32'h0050_0093, 0, 0);
    do_req(0, 0, 3'd0, 32'h0000_0203, 32'h0, 32'h80FF_1234, 0, 0);
    do_req(0, 0, 3'd5, 32'h0000_0202, 32'h0, 32'h80FF_1234, 0, 0);
    do_req(0, 1, 3'd1, 32'h0000_0302, 32'hDEAD_BEEF, 32'h1111_2222, 1, 0);
    do_req(0, 0, 3'd2, 32'h0000_0401, 32'h0, 32'h0, 0, 0);
    do_req(0, 1, 3'd3, 32'h0000_0500, 32'h0, 32'h0, 0, 0);
    do_req(0, 0, 3'd2, 32'h0000_0604, 32'h0, 32'hCAFE_F00D, 3, 0);
    do_req(1, 0, 3'd0, 32'h0000_0700, 32'h0, 32'h0, 0, 1);

    // Async reset in the middle of an ISSUE phase
    @(negedge clk);
    req_valid = 1'b1; req_fetch = 1'b1; req_write = 1'b0;
    funct3 = 3'd2; addr = 32'h0000_0800;
    bus_q.push_back(bus_model(1, 0, 3'd2, 32'h0000_0800, 32'h0));
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    bus_q.delete();
    ir_m  = '0;
    mdr_m = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req(1, 0, 3'd2, 32'h0000_0900, 32'h0, 32'h1234_5678, 1, 0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      bit          fe, wr;
      logic [2:0]  f3;
      logic [31:0] a;
      fe = ($urandom_range(0, 3) == 0);
      wr = 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_req(fe, wr, f3, a, $urandom, $urandom, $urandom_range(0, 4), 0);
    end

    repeat (4) @(negedge clk);
    check("pending_responses", 32'(resp_q.size()), 32'd0);
    check("pending_bus", 32'(bus_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
